// File: rtl/mesa_update_arbiter.sv
// Round-robin arbiter that feeds validated Libre/Ocupada/Reservada updates into a one-hot table bank.
// Optional macro RES_TIMEOUT_EN adds per-table reservation expiry driven by the tick pulse.
module mesa_update_arbiter #(
    parameter int NREQ      = 4,
    parameter int NMESA     = 4,
    parameter int MW        = 2,
    parameter int RES_TICKS = 60,
    parameter int TW        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*MW-1:0] req_mesa,
    input  logic [NREQ*2-1:0]  req_est,
    input  logic               tick,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    nack,
    output logic [NMESA-1:0]   M_L,
    output logic [NMESA-1:0]   M_O,
    output logic [NMESA-1:0]   M_R,
    output logic [NMESA-1:0]   expired
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        EST_L   = 2'd0,
        EST_O   = 2'd1,
        EST_R   = 2'd2,
        EST_BAD = 2'd3
    } est_e;

    function automatic logic [PW-1:0] wrap_idx(input int v);
        return PW'(v % NREQ);
    endfunction

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;
    logic             found;
    logic             gnt_vld;
    logic [PW-1:0]    gnt_idx;
    logic [MW-1:0]    gnt_mesa;
    est_e             gnt_est;
    logic [NREQ-1:0]  inflight;
    logic [NREQ-1:0]  elig;
    logic [NMESA-1:0] hit;
    logic [NMESA-1:0] wr;
    logic [NMESA-1:0] expire;
    logic             accept;

    // The in-flight grant is masked as well, so a held req is not granted twice before its ack.
    always_comb begin
        inflight = '0;
        if (gnt_vld) inflight[gnt_idx] = 1'b1;
    end

    assign elig = req & ~ack & ~nack & ~inflight;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[wrap_idx(int'(ptr) + k)]) begin
                found = 1'b1;
                sel   = wrap_idx(int'(ptr) + k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            gnt_vld  <= 1'b0;
            gnt_idx  <= '0;
            gnt_mesa <= '0;
            gnt_est  <= EST_L;
        end else begin
            gnt_vld <= found;
            if (found) begin
                gnt_idx  <= sel;
                gnt_mesa <= req_mesa[int'(sel)*MW +: MW];
                gnt_est  <= est_e'(req_est[int'(sel)*2 +: 2]);
                ptr      <= wrap_idx(int'(sel) + 1);
            end
        end
    end

    // An out-of-range index matches no table, so it is rejected like an illegal state code.
    always_comb begin
        hit = '0;
        for (int t = 0; t < NMESA; t++) begin
            hit[t] = gnt_vld && (gnt_mesa == MW'(t));
        end
        accept = (|hit) && (gnt_est != EST_BAD)
                 && !((|(hit & M_O)) && (gnt_est == EST_R));
        wr     = accept ? hit : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= '0;
            nack <= '0;
        end else begin
            ack  <= accept ? inflight : '0;
            nack <= (gnt_vld && !accept) ? inflight : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_L <= '1;
            M_O <= '0;
            M_R <= '0;
        end else begin
            for (int t = 0; t < NMESA; t++) begin
                if (wr[t]) begin
                    M_L[t] <= (gnt_est == EST_L);
                    M_O[t] <= (gnt_est == EST_O);
                    M_R[t] <= (gnt_est == EST_R);
                end else if (expire[t]) begin
                    M_L[t] <= 1'b1;
                    M_R[t] <= 1'b0;
                end
            end
        end
    end

`ifdef RES_TIMEOUT_EN
    logic [TW-1:0] cnt [NMESA];

    // A write on the same edge wins over an expiry of the same table.
    always_comb begin
        expire = '0;
        for (int t = 0; t < NMESA; t++) begin
            expire[t] = tick && M_R[t] && (cnt[t] == TW'(1)) && !wr[t];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NMESA; t++) cnt[t] <= '0;
            expired <= '0;
        end else begin
            for (int t = 0; t < NMESA; t++) begin
                if (wr[t]) begin
                    cnt[t] <= (gnt_est == EST_R) ? TW'(RES_TICKS) : '0;
                end else if (tick && M_R[t] && (cnt[t] != '0)) begin
                    cnt[t] <= cnt[t] - TW'(1);
                end
            end
            expired <= expire;
        end
    end
`else
    localparam int unused_cfg = RES_TICKS + TW;
    logic unused_tick;

    assign unused_tick = tick;
    assign expire      = '0;
    assign expired     = '0;
`endif

endmodule

// File: tb/tb_mesa_update_arbiter.sv
// Randomized and directed bench for mesa_update_arbiter against a cycle-level behavioural model.
// Honours RES_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_mesa_update_arbiter;

    localparam int NREQ      = 4;
    localparam int NMESA     = 4;
    localparam int MW        = 3;
    localparam int RES_TICKS = 3;
    localparam int TW        = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req;
    logic [NREQ*MW-1:0] req_mesa;
    logic [NREQ*2-1:0]  req_est;
    logic               tick;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    nack;
    logic [NMESA-1:0]   M_L;
    logic [NMESA-1:0]   M_O;
    logic [NMESA-1:0]   M_R;
    logic [NMESA-1:0]   expired;

    int checks   = 0;
    int failures = 0;
    bit rnd_en   = 1'b0;

    // Model state: table states (0=L,1=O,2=R), reservation countdowns, pointer and pending grant.
    int              st  [NMESA];
    int              cnt [NMESA];
    int              m_ptr;
    bit              pend_v;
    int              pend_idx;
    int              pend_mesa;
    int              pend_est;
    logic [NREQ-1:0] m_ack;
    logic [NREQ-1:0] m_nack;
    logic [NMESA-1:0] m_exp;

    mesa_update_arbiter #(
        .NREQ(NREQ), .NMESA(NMESA), .MW(MW), .RES_TICKS(RES_TICKS), .TW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mesa(req_mesa), .req_est(req_est),
        .tick(tick), .ack(ack), .nack(nack), .M_L(M_L), .M_O(M_O), .M_R(M_R),
        .expired(expired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int t = 0; t < NMESA; t++) begin
            st[t]  = 0;
            cnt[t] = 0;
        end
        m_ptr  = 0;
        pend_v = 1'b0;
        m_ack  = '0;
        m_nack = '0;
        m_exp  = '0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT is about to sample.
    task automatic modelEdge();
        logic [NREQ-1:0]  ack_n;
        logic [NREQ-1:0]  nack_n;
        logic [NMESA-1:0] exp_n;
        int wt;
        int best;
        ack_n  = '0;
        nack_n = '0;
        exp_n  = '0;
        wt     = -1;
        if (pend_v) begin
            if (pend_est != 3 && pend_mesa < NMESA && !(pend_est == 2 && st[pend_mesa] == 1)) begin
                ack_n[pend_idx] = 1'b1;
                wt = pend_mesa;
            end else begin
                nack_n[pend_idx] = 1'b1;
            end
        end
`ifdef RES_TIMEOUT_EN
        for (int t = 0; t < NMESA; t++) begin
            if (t != wt && tick && st[t] == 2 && cnt[t] > 0) begin
                cnt[t] = cnt[t] - 1;
                if (cnt[t] == 0) begin
                    st[t]    = 0;
                    exp_n[t] = 1'b1;
                end
            end
        end
`endif
        if (wt >= 0) begin
            st[wt]  = pend_est;
            cnt[wt] = (pend_est == 2) ? RES_TICKS : 0;
        end
        best = -1;
        for (int d = 0; d < NREQ && best < 0; d++) begin
            int i;
            i = (m_ptr + d) % NREQ;
            if (req[i] && !m_ack[i] && !m_nack[i] && !(pend_v && pend_idx == i)) best = i;
        end
        if (best >= 0) begin
            pend_v    = 1'b1;
            pend_idx  = best;
            pend_mesa = int'(req_mesa[best*MW +: MW]);
            pend_est  = int'(req_est[best*2 +: 2]);
            m_ptr     = (best + 1) % NREQ;
        end else begin
            pend_v = 1'b0;
        end
        m_ack  = ack_n;
        m_nack = nack_n;
        m_exp  = exp_n;
    endtask

    task automatic startReq(input int i, input int mesa, input int est);
        req[i]               = 1'b1;
        req_mesa[i*MW +: MW] = MW'(mesa);
        req_est[i*2 +: 2]    = 2'(est);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] blocked);
        int r;
        tick = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && !blocked[i] && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                startReq(i, $urandom_range(0, 5), (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3);
            end
        end
    endtask

    task automatic checkAll();
        logic [NMESA-1:0] el;
        logic [NMESA-1:0] eo;
        logic [NMESA-1:0] er;
        for (int t = 0; t < NMESA; t++) begin
            el[t] = (st[t] == 0);
            eo[t] = (st[t] == 1);
            er[t] = (st[t] == 2);
        end
        checkOutput("ack", ack, m_ack);
        checkOutput("nack", nack, m_nack);
        checkOutput("M_L", M_L, el);
        checkOutput("M_O", M_O, eo);
        checkOutput("M_R", M_R, er);
        checkOutput("expired", expired, m_exp);
    endtask

    // One clock: model edge, DUT edge, check at negedge, then requesters react to ack/nack.
    task automatic stepCycle();
        logic [NREQ-1:0] dropped;
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        tick    = 1'b0;
        dropped = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (m_ack[i] || m_nack[i])) begin
                req[i]     = 1'b0;
                dropped[i] = 1'b1;
            end
        end
        if (rnd_en) applyStimulus(dropped);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((req != '0 || pend_v) && k < 50) begin
            stepCycle();
            k++;
        end
        if (k >= 50) checkOutput("drain_timeout", 32'(req), 32'd0);
    endtask

    initial begin
        req      = '0;
        req_mesa = '0;
        req_est  = '0;
        tick     = 1'b0;
        modelReset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_M_L", M_L, 32'hf);
        checkOutput("rst_M_O", M_O, 32'h0);
        checkOutput("rst_M_R", M_R, 32'h0);
        checkOutput("rst_acks", {ack, nack}, 32'h0);
        rst_n = 1'b1;
        repeat (5) stepCycle();

        startReq(0, 2, 1);
        drain();
        checkOutput("occ_M_O", M_O, 32'b0100);
        checkOutput("occ_M_L", M_L, 32'b1011);
        startReq(1, 2, 2);
        drain();
        checkOutput("o2r_M_O", M_O, 32'b0100);
        startReq(2, 2, 0);
        drain();

        for (int i = 0; i < NREQ; i++) startReq(i, i, 2);
        drain();
        checkOutput("allr_M_R", M_R, 32'hf);
        startReq(1, 0, 1);
        startReq(3, 1, 1);
        drain();
        checkOutput("pair_M_O", M_O, 32'b0011);

        startReq(0, 3, 3);
        drain();
        startReq(2, 5, 1);
        drain();
        checkOutput("illegal_M_R", M_R, 32'b1100);
        checkOutput("illegal_M_O", M_O, 32'b0011);

        startReq(0, 1, 0);
        drain();
        startReq(0, 1, 2);
        drain();
        repeat (3) begin
            tick = 1'b1;
            stepCycle();
            stepCycle();
        end
`ifdef RES_TIMEOUT_EN
        checkOutput("timeout_M_L1", 32'(M_L[1]), 32'd1);
`else
        checkOutput("persist_M_R1", 32'(M_R[1]), 32'd1);
`endif
        startReq(0, 1, 2);
        drain();
        repeat (2) begin
            tick = 1'b1;
            stepCycle();
            stepCycle();
        end
        startReq(0, 1, 1);
        stepCycle();
        tick = 1'b1;
        stepCycle();
        drain();
        checkOutput("race_M_O1", 32'(M_O[1]), 32'd1);

        rnd_en = 1'b1;
        repeat (400) stepCycle();
        rnd_en = 1'b0;
        drain();

        startReq(0, 0, 1);
        drain();
        startReq(3, 2, 0);
        startReq(2, 3, 2);
        stepCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_M_L", M_L, 32'hf);
        checkOutput("midrst_M_O", M_O, 32'h0);
        checkOutput("midrst_M_R", M_R, 32'h0);
        checkOutput("midrst_acks", {ack, nack, expired}, 32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        repeat (3) stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
